// File: rtl/regfile_wb_arb_pkg.sv
// Shared widths, reset polarity and queue entry layout for the regfile write-port arbiter.
// The fixed slot count bounds the queue storage; only the first DEPTH slots are ever used.
package regfile_wb_arb_pkg;

  localparam int          RegBus         = 32;
  localparam int          RegAddrBus     = 5;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        WriteEnable    = 1'b1;
  localparam logic        WbArbRstEnable = 1'b0;
  localparam int          WbArbDepth     = 2;
  localparam int          MaxDepth       = 4;

  typedef struct packed {
    logic                  vld;
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wb_ent_t;

  // r0 is hardwired, so writes and hazards on it never matter
  function automatic logic addr_live(input logic [RegAddrBus-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular queue of secondary writeback results with per-entry valid, address kill
// and pending-destination match for two decode check ports.
module wb_arb_fifo
  import regfile_wb_arb_pkg::*;
#(
  parameter int DEPTH = WbArbDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [RegAddrBus-1:0] push_addr,
  input  logic [RegBus-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [RegAddrBus-1:0] kill_addr,
  input  logic [RegAddrBus-1:0] chk_addr1,
  input  logic [RegAddrBus-1:0] chk_addr2,
  output wb_ent_t               head,
  output logic                  empty,
  output logic                  full,
  output logic                  hit1,
  output logic                  hit2
);

  logic                  vld_q  [MaxDepth];
  logic [RegAddrBus-1:0] addr_q [MaxDepth];
  logic [RegBus-1:0]     data_q [MaxDepth];
  logic [1:0]            head_ptr;
  logic [1:0]            tail_ptr;
  logic [2:0]            count;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty = (count == 3'd0);
  assign full  = (count == 3'(DEPTH));
  assign head  = {vld_q[head_ptr], addr_q[head_ptr], data_q[head_ptr]};

  // Kill first, then pop, then push: a push into the slot being freed must win.
  always_ff @(posedge clk) begin
    if (rst == WbArbRstEnable) begin
      head_ptr <= 2'd0;
      tail_ptr <= 2'd0;
      count    <= 3'd0;
      for (int i = 0; i < MaxDepth; i++) vld_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < MaxDepth; i++) begin
        if (kill_en && vld_q[i] && addr_q[i] == kill_addr) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[head_ptr] <= 1'b0;
        head_ptr        <= ptr_inc(head_ptr);
      end
      if (push) begin
        vld_q[tail_ptr] <= 1'b1;
        tail_ptr        <= ptr_inc(tail_ptr);
      end
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_ptr] <= push_addr;
      data_q[tail_ptr] <= push_data;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < MaxDepth; i++) begin
      if (vld_q[i] && addr_live(chk_addr1) && addr_q[i] == chk_addr1) hit1 = 1'b1;
      if (vld_q[i] && addr_live(chk_addr2) && addr_q[i] == chk_addr2) hit2 = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Shares the register file write port between the pipeline writeback (fixed priority)
// and a queued secondary result source, with starvation-driven pipeline stall.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int DEPTH      = WbArbDepth,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [RegAddrBus-1:0] p_waddr,
  input  logic [RegBus-1:0]     p_wdata,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RegAddrBus-1:0] s_waddr,
  input  logic [RegBus-1:0]     s_wdata,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  input  logic [RegAddrBus-1:0] chk_addr1,
  input  logic [RegAddrBus-1:0] chk_addr2,
  output logic                  pend_hit1,
  output logic                  pend_hit2,
  output logic                  stall_o
);

  wb_ent_t               head;
  logic                  empty;
  logic                  full;
  logic                  kill_en;
  logic                  hs_p0;
  logic                  s_keep_p0;
  logic                  push_p0;
  logic                  pop_p0;
  logic                  sel_we_p0;
  logic [RegAddrBus-1:0] sel_addr_p0;
  logic [RegBus-1:0]     sel_data_p0;
  logic [3:0]            starve_q;

  assign s_ready   = !full && (rst != WbArbRstEnable);
  assign hs_p0     = s_valid && s_ready;
  assign kill_en   = p_we && addr_live(p_waddr);
  // A concurrent pipeline write to the same register is newer, so the incoming result is stale.
  assign s_keep_p0 = hs_p0 && addr_live(s_waddr) && !(p_we && p_waddr == s_waddr);
  assign push_p0   = s_keep_p0 && (p_we || !empty);

  always_comb begin
    sel_we_p0   = 1'b0;
    sel_addr_p0 = '0;
    sel_data_p0 = ZeroWord;
    pop_p0      = 1'b0;
    if (p_we) begin
      sel_we_p0   = addr_live(p_waddr);
      sel_addr_p0 = p_waddr;
      sel_data_p0 = p_wdata;
    end else if (!empty) begin
      pop_p0      = 1'b1;
      sel_we_p0   = head.vld;
      sel_addr_p0 = head.addr;
      sel_data_p0 = head.data;
    end else if (s_keep_p0) begin
      sel_we_p0   = WriteEnable;
      sel_addr_p0 = s_waddr;
      sel_data_p0 = s_wdata;
    end
  end

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_p0),
    .push_addr (s_waddr),
    .push_data (s_wdata),
    .pop       (pop_p0),
    .kill_en   (kill_en),
    .kill_addr (p_waddr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .hit1      (pend_hit1),
    .hit2      (pend_hit2)
  );

  // Output stage p0 -> registered write port and stall request
  always_ff @(posedge clk) begin
    if (rst == WbArbRstEnable) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= ZeroWord;
      stall_o  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      we    <= sel_we_p0;
      waddr <= sel_addr_p0;
      wdata <= sel_data_p0;
      if (starve_q == 4'(STARVE_MAX)) begin
        stall_o  <= 1'b1;
        starve_q <= 4'd0;
      end else begin
        stall_o <= 1'b0;
        if (pop_p0 || empty) starve_q <= 4'd0;
        else if (p_we)       starve_q <= starve_q + 4'd1;
      end
    end
  end

endmodule
